// File: rtl/matrix_pack_fifo_if.sv
// matrix_pack_fifo_if: cell push/flush side and packed-word pop side of the pack FIFO.
interface matrix_pack_fifo_if #(
    parameter int DataWidth = 64,
    parameter int CellWidth = 2,
    parameter int Depth = 4
);
    localparam int CellsPerWord = DataWidth / CellWidth;
    logic [CellWidth-1:0] data_i;
    logic push_i;
    logic flush_i;
    logic full_o;
    logic [DataWidth-1:0] data_o;
    logic [$clog2(CellsPerWord+1)-1:0] ncells_o;
    logic valid_o;
    logic pop_i;
    logic [$clog2(Depth+1)-1:0] count_o;
    modport master (
        output data_i, push_i, flush_i, pop_i,
        input full_o, data_o, ncells_o, valid_o, count_o
    );
    modport slave (
        input data_i, push_i, flush_i, pop_i,
        output full_o, data_o, ncells_o, valid_o, count_o
    );
endinterface

// File: rtl/matrix_pack_fifo.sv
// matrix_pack_fifo: packs ternary cells LSB-first into words and queues them with a valid-cell count.
module matrix_pack_fifo #(
    parameter int DataWidth = 64,
    parameter int CellWidth = 2,
    parameter int Depth = 4
) (
    input logic clk_i,
    input logic rst_i,
    matrix_pack_fifo_if.slave bus
);
    localparam int CellsPerWord = DataWidth / CellWidth;
    localparam int IW = $clog2(CellsPerWord);
    localparam int NW = $clog2(CellsPerWord + 1);
    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    logic [IW-1:0] r_idx;
    logic [DataWidth-1:0] r_pack;
    logic [DataWidth-1:0] r_mem [Depth];
    logic [NW-1:0] r_ncnt [Depth];
    logic [PW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_count;

    logic w_full, w_push, w_flush, w_last, w_enq, w_pop;
    logic [DataWidth-1:0] w_cell, w_word;
    logic [NW-1:0] w_n;

    // Flags come only from the registered count, so a same-cycle pop never unblocks a push.
    assign w_full = r_count == CW'(Depth);
    assign w_push = bus.push_i && !w_full;
    assign w_flush = bus.flush_i && !w_full;
    assign w_pop = bus.pop_i && r_count != '0;
    assign w_cell = {{(DataWidth-CellWidth){1'b0}}, bus.data_i} << (r_idx * CellWidth);
    assign w_word = w_push ? (r_pack | w_cell) : r_pack;
    assign w_last = w_push && r_idx == IW'(CellsPerWord - 1);
    assign w_enq = w_last || (w_flush && (r_idx != '0 || w_push));
    assign w_n = NW'(r_idx) + NW'(w_push);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx <= '0;
            r_pack <= '0;
            r_rd <= '0;
            r_wr <= '0;
            r_count <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
                r_ncnt[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_mem[r_wr] <= w_word;
                r_ncnt[r_wr] <= w_n;
                r_wr <= r_wr + 1'b1;
                r_idx <= '0;
                r_pack <= '0;
            end else if (w_push) begin
                r_idx <= r_idx + 1'b1;
                r_pack <= w_word;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_enq) - CW'(w_pop);
        end
    end

    assign bus.full_o = w_full;
    assign bus.valid_o = r_count != '0;
    assign bus.count_o = r_count;
    assign bus.data_o = r_mem[r_rd];
    assign bus.ncells_o = r_ncnt[r_rd];
endmodule

// File: tb/tb_matrix_pack_fifo.sv
// tb_matrix_pack_fifo: directed vectors with hand-computed packed words for an 8-bit, depth-2 FIFO.
module tb_matrix_pack_fifo;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int n_chk = 0;
    int n_pass = 0;

    matrix_pack_fifo_if #(.DataWidth(8), .CellWidth(2), .Depth(2)) bus ();
    matrix_pack_fifo #(.DataWidth(8), .CellWidth(2), .Depth(2)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic fl);
        bus.data_i = c;
        bus.push_i = 1'b1;
        bus.flush_i = fl;
        step();
        bus.push_i = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    task automatic pop();
        bus.pop_i = 1'b1;
        step();
        bus.pop_i = 1'b0;
    endtask

    task automatic flush();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
    endtask

    initial begin
        bus.data_i = '0;
        bus.push_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.pop_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_full", bus.full_o, 0);
        chk("rst_count", bus.count_o, 0);
        chk("rst_data", bus.data_o, 0);
        chk("rst_ncells", bus.ncells_o, 0);

        push(2'b01, 0); push(2'b11, 0); push(2'b00, 0); push(2'b01, 0);
        chk("w1_valid", bus.valid_o, 1);
        chk("w1_data", bus.data_o, 8'h4D);
        chk("w1_ncells", bus.ncells_o, 4);
        chk("w1_count", bus.count_o, 1);
        pop();
        chk("w1_pop_count", bus.count_o, 0);

        push(2'b11, 0); push(2'b10, 0); flush();
        chk("fl_data", bus.data_o, 8'h0B);
        chk("fl_ncells", bus.ncells_o, 2);
        flush();
        chk("fl_idle_count", bus.count_o, 1);
        pop();

        for (int i = 0; i < 4; i++) push(2'b01, 0);
        for (int i = 0; i < 4; i++) push(2'b10, 0);
        chk("full_count", bus.count_o, 2);
        chk("full_flag", bus.full_o, 1);
        chk("full_head", bus.data_o, 8'h55);
        push(2'b11, 0);
        chk("full_ign_count", bus.count_o, 2);
        bus.data_i = 2'b11;
        bus.push_i = 1'b1;
        bus.pop_i = 1'b1;
        step();
        bus.pop_i = 1'b0;
        chk("unfull_flag", bus.full_o, 0);
        chk("unfull_count", bus.count_o, 1);
        step();
        bus.push_i = 1'b0;
        chk("held_count", bus.count_o, 1);
        chk("held_head", bus.data_o, 8'hAA);
        flush();
        pop();
        chk("cell0_data", bus.data_o, 8'h03);
        chk("cell0_ncells", bus.ncells_o, 1);
        pop();

        pop();
        chk("empty_pop_valid", bus.valid_o, 0);
        chk("empty_pop_count", bus.count_o, 0);
        push(2'b01, 1);
        chk("pf1_count", bus.count_o, 1);
        bus.data_i = 2'b10;
        bus.push_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.pop_i = 1'b1;
        step();
        bus.push_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.pop_i = 1'b0;
        chk("encpop_count", bus.count_o, 1);
        chk("encpop_data", bus.data_o, 8'h02);
        chk("encpop_ncells", bus.ncells_o, 1);
        pop();

        push(2'b01, 0); push(2'b01, 0); push(2'b01, 0); push(2'b11, 1);
        chk("lastfl_count", bus.count_o, 1);
        chk("lastfl_data", bus.data_o, 8'hD5);
        chk("lastfl_ncells", bus.ncells_o, 4);
        push(2'b10, 1);
        chk("one_count", bus.count_o, 2);
        pop();
        chk("one_data", bus.data_o, 8'h02);
        chk("one_ncells", bus.ncells_o, 1);
        pop();

        push(2'b01, 1);
        push(2'b11, 0); push(2'b11, 0); push(2'b11, 0);
        chk("pre_rst_count", bus.count_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mid_rst_valid", bus.valid_o, 0);
        chk("mid_rst_count", bus.count_o, 0);
        for (int i = 0; i < 4; i++) push(2'b10, 0);
        chk("post_rst_data", bus.data_o, 8'hAA);
        chk("post_rst_ncells", bus.ncells_o, 4);
        chk("post_rst_count", bus.count_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
